pc_fetch: RTL and testbench

- Program-counter and instruction-fetch sequencer for the 4-bit microcode processor.
- Drives the instruction-memory address and captures the 8-bit instruction word.
- Presents the instruction as `instr_o` to the jump-decode block for the datapath.
- Consumes the jump address `pc_count` that the decoder returns, loading the PC with it or incrementing.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_reg.sv | 42 ++++
 rtl/pc_fetch.sv | 141 ++++++++++++++
 tb/tb_pc_fetch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 4-bit microcode processor front end.
//   CPU_ADDR_W  - PC / instruction-memory address width
//   CPU_INSTR_W - instruction word width
//   CNT_W       - width of the execute-cycle counter (EXEC_CYCLES up to 15)
//   INSTR_NOP   - instruction value presented while nothing has been fetched
//   fetch_state_e - sequencer states (ST_HOLD only reachable with single-step)
package cpu_pkg;

  localparam int CPU_ADDR_W  = 4;
  localparam int CPU_INSTR_W = 8;
  localparam int CNT_W       = 4;

  localparam logic [7:0] INSTR_NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program-counter register.
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low clear
//   load_en   - load pc with load_val (jump)
//   inc_en    - increment pc, wrapping modulo 2^W
//   load_val  - jump target
//   pc_o      - current program counter
// load_en has priority over inc_en; the sequencer never asserts both.
module pc_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic         inc_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc_o
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + W'(1);  // natural wrap at 2^W
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter and instruction-fetch sequencer.
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   run         - 1: fetch/execute continuously; 0: stop at next instruction boundary
//   step        - (PC_FETCH_SINGLE_STEP_EN only) advance one instruction from HOLD
//   mem_addr    - instruction-memory address (always the current PC)
//   mem_rd      - read request, high throughout FETCH
//   mem_data    - instruction word from memory
//   mem_ack     - memory data valid (any number of wait cycles)
//   instr_o     - registered instruction to the jump decoder
//   instr_valid - instr_o is being executed this cycle
//   pc_count    - jump target from decoder, 0 = sequential; sampled on last EXEC cycle
//   pc          - current program counter
// Optional feature macro: PC_FETCH_SINGLE_STEP_EN (adds step input and HOLD state).
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int INSTR_W     = CPU_INSTR_W,
  parameter int EXEC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
`ifdef PC_FETCH_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid,
  input  logic [ADDR_W-1:0]  pc_count,
  output logic [ADDR_W-1:0]  pc
);

  fetch_state_e       state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [INSTR_W-1:0] instr_q;
  logic               mem_rd_q;
  logic               valid_q;

  logic [ADDR_W-1:0]  pc_cur;
  logic               last_exec;
  logic               jump;
  logic               load_en;
  logic               inc_en;

  // pc_count is only meaningful once the bus flags have settled, i.e. on the
  // final execute cycle; a zero target means "fall through".
  assign last_exec = (state_q == ST_EXEC) && (cnt_q == '0);
  assign jump      = |pc_count;
  assign load_en   = last_exec && jump;
  assign inc_en    = last_exec && !jump;

  pc_reg #(
    .W (ADDR_W)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_en),
    .inc_en   (inc_en),
    .load_val (pc_count),
    .pc_o     (pc_cur)
  );

  // mem_rd and instr_valid are registered alongside the state so they are
  // exactly the FETCH and EXEC decodes without any output glitching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      instr_q  <= INSTR_W'(INSTR_NOP);
      mem_rd_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q  <= ST_FETCH;
            mem_rd_q <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (mem_ack) begin
            instr_q  <= mem_data;
            cnt_q    <= CNT_W'(EXEC_CYCLES - 1);
            state_q  <= ST_EXEC;
            mem_rd_q <= 1'b0;
            valid_q  <= 1'b1;
          end
        end

        ST_EXEC: begin
          if (cnt_q == '0) begin
            // PC is updated on this same edge by u_pc_reg.
            valid_q <= 1'b0;
            if (run) begin
`ifdef PC_FETCH_SINGLE_STEP_EN
              state_q <= ST_HOLD;
`else
              state_q  <= ST_FETCH;
              mem_rd_q <= 1'b1;
`endif
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

`ifdef PC_FETCH_SINGLE_STEP_EN
        ST_HOLD: begin
          if (!run) begin
            state_q <= ST_IDLE;
          end else if (step) begin
            state_q  <= ST_FETCH;
            mem_rd_q <= 1'b1;
          end
        end
`endif

        default: begin
          state_q  <= ST_IDLE;
          mem_rd_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr    = pc_cur;
  assign pc          = pc_cur;
  assign mem_rd      = mem_rd_q;
  assign instr_valid = valid_q;
  assign instr_o     = instr_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch (default build).
// The reference model works per instruction: expected fetch address,
// expected instruction word, and the next PC from the jump rule.
module tb_pc_fetch;

  localparam int AW = 4;
  localparam int IW = 8;
  localparam int EC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [IW-1:0] mem_data;
  logic          mem_ack;
  logic [IW-1:0] instr_o;
  logic          instr_valid;
  logic [AW-1:0] pc_count;
  logic [AW-1:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  logic [IW-1:0] mem [16];
  logic [AW-1:0] exp_pc;
  logic [IW-1:0] exp_instr;

  always #5 clk = ~clk;

  pc_fetch #(
    .ADDR_W      (AW),
    .INSTR_W     (IW),
    .EXEC_CYCLES (EC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .instr_o     (instr_o),
    .instr_valid (instr_valid),
    .pc_count    (pc_count),
    .pc          (pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge that put the DUT in FETCH.
  // Leaves the DUT in FETCH of the next instruction.
  task automatic run_instr(input int waits, input logic [AW-1:0] jmp,
                           input logic [AW-1:0] junk, input bit run_after);
    bit last;
    for (int w = 0; w <= waits; w++) begin
      check_eq("fetch_rd", 32'(mem_rd), 32'd1);
      check_eq("fetch_addr", 32'(mem_addr), 32'(exp_pc));
      check_eq("fetch_valid", 32'(instr_valid), 32'd0);
      check_eq("fetch_instr_hold", 32'(instr_o), 32'(exp_instr));
      mem_ack  = (w == waits);
      mem_data = (w == waits) ? mem[mem_addr] : IW'($urandom);
      pc_count = junk;
      run      = 1'($urandom_range(0, 1));
      step_clk();
    end
    mem_ack   = 1'b0;
    exp_instr = mem[exp_pc];
    for (int e = 0; e < EC; e++) begin
      check_eq("exec_valid", 32'(instr_valid), 32'd1);
      check_eq("exec_rd", 32'(mem_rd), 32'd0);
      check_eq("exec_instr", 32'(instr_o), 32'(exp_instr));
      check_eq("exec_pc", 32'(pc), 32'(exp_pc));
      last     = (e == EC - 1);
      pc_count = last ? jmp : junk;
      run      = last ? run_after : 1'($urandom_range(0, 1));
      mem_ack  = 1'($urandom_range(0, 1));
      mem_data = IW'($urandom);
      step_clk();
    end
    mem_ack  = 1'b0;
    pc_count = '0;
    $display("INSTR pc=%h instr=%h waits=%0d pc_count=%h run=%0d",
             exp_pc, exp_instr, waits, jmp, run_after);
    exp_pc = (jmp != '0) ? jmp : exp_pc + AW'(1);
    if (!run_after) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("idle_rd", 32'(mem_rd), 32'd0);
        check_eq("idle_valid", 32'(instr_valid), 32'd0);
        check_eq("idle_pc", 32'(pc), 32'(exp_pc));
        check_eq("idle_instr", 32'(instr_o), 32'(exp_instr));
        run     = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        step_clk();
      end
      mem_ack = 1'b0;
      run     = 1'b1;
      step_clk();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = IW'($urandom);
    mem[0] = 8'hA0;
    mem[1] = 8'hA1;
    rst_n = 1'b0;
    run = 1'b0;
    mem_ack = 1'b0;
    mem_data = '0;
    pc_count = '0;
    exp_pc = '0;
    exp_instr = '0;

    #12;
    check_eq("rst_rd", 32'(mem_rd), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_instr", 32'(instr_o), 32'd0);
    rst_n = 1'b1;
    step_clk();
    check_eq("idle_rd0", 32'(mem_rd), 32'd0);
    run = 1'b1;
    step_clk();

    // Directed program: start, wait states, jumps, wrap, stop/resume.
    run_instr(0, 4'd0,  4'd0, 1'b1);   // 0 -> 1
    run_instr(0, 4'd0,  4'd0, 1'b1);   // 1 -> 2
    run_instr(3, 4'd5,  4'd0, 1'b1);   // 2 (3 waits) -> 5
    run_instr(0, 4'd9,  4'd0, 1'b1);   // 5 -> 9 jump
    run_instr(0, 4'd5,  4'd0, 1'b1);   // 9 -> 5
    run_instr(0, 4'd0,  4'd9, 1'b1);   // 5, early pc_count=9 ignored -> 6
    run_instr(1, 4'd15, 4'd0, 1'b1);   // 6 -> 15
    run_instr(0, 4'd0,  4'd0, 1'b1);   // 15 -> 0 wrap
    run_instr(0, 4'd3,  4'd0, 1'b1);   // 0 -> 3
    run_instr(0, 4'd0,  4'd0, 1'b0);   // 3 -> 4, stop then resume
    run_instr(2, 4'd0,  4'd0, 1'b1);   // 4 -> 5

    // Randomized program.
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] j;
      j = ($urandom_range(0, 1) == 0) ? '0 : AW'($urandom);
      run_instr(int'($urandom_range(0, 3)), j, AW'($urandom),
                ($urandom_range(0, 3) != 0));
    end

    // Async reset in the middle of a fetch at pc=7.
    run_instr(0, 4'd7, 4'd0, 1'b1);
    check_eq("pre_rst_rd", 32'(mem_rd), 32'd1);
    check_eq("pre_rst_addr", 32'(mem_addr), 32'd7);
    mem_ack = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rd", 32'(mem_rd), 32'd0);
    check_eq("async_pc", 32'(pc), 32'd0);
    check_eq("async_addr", 32'(mem_addr), 32'd0);
    check_eq("async_valid", 32'(instr_valid), 32'd0);
    check_eq("async_instr", 32'(instr_o), 32'd0);
    #2;
    rst_n = 1'b1;
    run = 1'b1;
    exp_pc = '0;
    exp_instr = '0;
    step_clk();
    run_instr(0, 4'd0, 4'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
